uart_rx_word: RTL
=================

Name: uart_rx_word

Overview:
- Receive side of the board's 8N1 UART link: samples the rx pin with 16x oversampling and recovers bytes.
- Packs four consecutive bytes little-endian into a 32-bit word and presents it on a valid/ready output port.
- Companion to the 32-bit transmit path; the same divisor/clock setup (12 MHz clk, 9600 baud) applies.

Parameters:
- DIVISOR, 78, clk cycles per oversample tick (12 MHz / (16 × 9600) ≈ 78); counter counts 0..DIVISOR-1.
- DVSR_BIT, 7, width of the tick counter; must satisfy 2^DVSR_BIT ≥ DIVISOR.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- o_data  output  32  assembled word; byte 0 received sits in [7:0].
- o_valid  output  1  o_data holds an unconsumed word.
- i_ready  input  1  consumer accepts the word when o_valid & i_ready at a clk edge.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: a completed word was dropped because the holding register was full.
- o_parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when the parity feature is compiled out.

Behaviour:
- Reset (reset=0, async): synchroniser flops = 1, FSM = IDLE, all counters = 0, o_data = 0, o_valid = 0, all error pulses = 0. Reset mid-frame abandons the frame and the partial word.
- rx passes through a 2-FF synchroniser. All decisions use the synchronised value (rxs), giving 2 clk of input latency.
- Tick generator: free-running counter 0..DIVISOR-1; `tick` is high for one clk at DIVISOR-1.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP. s = 4-bit tick count, n = bit count.
- IDLE: when rxs=0, go to START with s=0.
- START: on each tick s++. At s=7 (mid start bit):
  - rxs=0: go to DATA with s=0, n=0.
  - rxs=1: glitch; return to IDLE with no error.
- DATA: on tick s++. At s=15, shift rxs into the byte register LSB-first, set s=0, n++. After n = DATA_BITS go to PARITY if enabled, else STOP.
- STOP: at s=15 sample rxs, then go to IDLE.
  - rxs=1: byte accepted.
  - rxs=0: o_frame_err pulse; byte discarded; partial word cleared (byte index = 0).
- Word assembly: an accepted byte is written to lane idx (bits [8·idx+7 : 8·idx]), then idx++ (2-bit, wraps). When the byte lands in lane 3, the word is complete.
- Completion timing: o_valid rises on the clk after the stop-bit sample of byte 4.
- Completion with o_valid=0, or with o_valid=1 and i_ready=1 in that same cycle: load o_data and set o_valid=1. No word is lost.
- Completion with o_valid=1 and i_ready=0: new word dropped, held word unchanged, o_overrun pulse.
- o_valid clears on a handshake cycle with no simultaneous completion.
- o_data is stable while o_valid=1 and i_ready=0.
- A new start bit is detected immediately after returning to IDLE, so back-to-back frames are supported.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. PARITY state samples the bit at s=15. If the XOR of the data bits and the parity bit is 1, the byte is discarded, the partial word is cleared, and o_parity_err pulses. The STOP check still runs, and a frame error is also reported if present.
- Not defined: no PARITY state; frame is 8N1; o_parity_err is tied to 0.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - OVERSAMPLE=16, START_MID=7, LAST_TICK=15, BYTES_PER_WORD=4.
- Sub-module uart_baud_tick: the divisor counter with DIVISOR/DVSR_BIT parameters, producing `tick`. The transmit side can reuse it.

Test Plan (DIVISOR=4, so one bit = 64 clk):
- Send bytes 48,65,6C,6C back-to-back with i_ready=1 → single o_valid pulse, o_data=32'h6C6C6548, no error pulses.
- rx low for 20 clk then high (glitch shorter than half a bit) → FSM returns to IDLE, no byte accepted, no errors.
- Send 48,65 then byte 6C with stop bit low, then send 11,22,33,44 → one o_frame_err pulse, partial word discarded, next o_data=32'h44332211.
- Hold i_ready=0, send 8 bytes 01..08 → first word 32'h04030201 held, one o_overrun pulse at the 8th byte, o_data still 32'h04030201.
- Assert reset low mid-DATA of byte 3, release, send 4 fresh bytes AA,BB,CC,DD → o_data=32'hDDCCBBAA. With UART_RX_PARITY_EN, a wrong parity bit on byte 2 → o_parity_err pulse and word restarts.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive/transmit slice.
// Receiver FSM state encoding plus oversampling and word-packing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int OVERSAMPLE     = 16;
  localparam int START_MID      = 7;
  localparam int LAST_TICK      = OVERSAMPLE - 1;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divisor counter producing the 16x oversample tick.
// tick is high for one clk each time the counter reaches DIVISOR-1.
module uart_baud_tick #(
  parameter int DIVISOR  = 78,
  parameter int DVSR_BIT = 7
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [DVSR_BIT-1:0] LAST_COUNT = DVSR_BIT'(DIVISOR - 1);

  logic [DVSR_BIT-1:0] cnt_q;
  logic [DVSR_BIT-1:0] cnt_d;

  // Next count: wrap to zero after the last divisor step
  always_comb begin
    cnt_d = cnt_q + DVSR_BIT'(1);
    if (cnt_q == LAST_COUNT) begin
      cnt_d = '0;
    end
  end

  // Divisor counter register, async active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST_COUNT);

endmodule

// File: rtl/uart_rx_word.sv
// uart_rx_word: 16x-oversampled UART receiver packing four bytes little-endian
// into a 32-bit word on a valid/ready port. Frame is 8N1 by default; define
// UART_RX_PARITY_EN for 8E1 with a parity check and o_parity_err pulses.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int DIVISOR   = 78,
  parameter int DVSR_BIT  = 7,
  parameter int DATA_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_parity_err
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic tick;

  logic sync1_q;
  logic sync2_q;
  logic rxs;

  rx_state_e         state_q, state_d;
  logic [3:0]        s_q, s_d;
  logic [3:0]        n_q, n_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  logic [WORD_W-1:0] lane_word;
  logic              byte_done;
  logic              byte_ok;
  logic              complete;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
`endif

  uart_baud_tick #(
    .DIVISOR  (DIVISOR),
    .DVSR_BIT (DVSR_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchroniser for the asynchronous rx line, idles high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // Frame FSM, byte shifter, word packing and output handshake next-state logic
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    word_d      = word_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;
    byte_ok     = 1'b0;
    complete    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == 4'(START_MID)) begin
            if (!rxs) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == 4'(LAST_TICK)) begin
            s_d     = '0;
            shift_d = {rxs, shift_q[BYTE_W-1:1]};
            if (n_q == 4'(DATA_BITS - 1)) begin
              n_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 4'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == 4'(LAST_TICK)) begin
            s_d       = '0;
            par_bad_d = (^shift_q) ^ rxs;
            state_d   = STOP;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_q == 4'(LAST_TICK)) begin
            s_d         = '0;
            state_d     = IDLE;
            byte_done   = 1'b1;
            frame_err_d = ~rxs;
`ifdef UART_RX_PARITY_EN
            byte_ok      = rxs & ~par_bad_q;
            parity_err_d = par_bad_q;
            par_bad_d    = 1'b0;
`else
            byte_ok = rxs;
`endif
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    lane_word = word_q;
    lane_word[{idx_q, 3'b000} +: BYTE_W] = shift_q;

    if (byte_done) begin
      if (byte_ok) begin
        word_d = lane_word;
        idx_d  = idx_q + 2'd1;
        if (idx_q == LAST_LANE) begin
          complete = 1'b1;
        end
      end else begin
        idx_d = '0;
      end
    end

    if (complete) begin
      if (!valid_q || i_ready) begin
        data_d  = lane_word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers, async active-low reset abandons any frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity flag and parity error pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule
